// File: rtl/mem_port_arbiter_if.sv
// Bundle of the arbiter's requester, BRAM and response signals.
// slave is the arbiter side; master is the requester/BRAM side.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH   = 10,
  parameter int ROB_IX_WIDTH = 3
);
  logic                    flush_in;
  logic                    ld_valid_in;
  logic [31:0]             ld_addr_in;
  logic [ROB_IX_WIDTH-1:0] ld_rob_ix_in;
  logic                    ld_ready_out;
  logic                    st_valid_in;
  logic [31:0]             st_addr_in;
  logic [31:0]             st_data_in;
  logic [3:0]              st_strb_in;
  logic                    st_ready_out;
  logic                    mem_en_out;
  logic [3:0]              mem_we_out;
  logic [ADDR_WIDTH-1:0]   mem_addr_out;
  logic [31:0]             mem_wdata_out;
  logic [31:0]             mem_rdata_in;
  logic                    ld_resp_valid_out;
  logic [31:0]             ld_resp_data_out;
  logic [ROB_IX_WIDTH-1:0] ld_resp_rob_ix_out;

  modport slave (
    input  flush_in, ld_valid_in, ld_addr_in, ld_rob_ix_in,
    input  st_valid_in, st_addr_in, st_data_in, st_strb_in,
    input  mem_rdata_in,
    output ld_ready_out, st_ready_out,
    output mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out,
    output ld_resp_valid_out, ld_resp_data_out, ld_resp_rob_ix_out
  );

  modport master (
    output flush_in, ld_valid_in, ld_addr_in, ld_rob_ix_in,
    output st_valid_in, st_addr_in, st_data_in, st_strb_in,
    output mem_rdata_in,
    input  ld_ready_out, st_ready_out,
    input  mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out,
    input  ld_resp_valid_out, ld_resp_data_out, ld_resp_rob_ix_out
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data BRAM port between load issue and committed stores,
// registers the access and returns tagged load data through a tag pipeline.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int ROB_IX_WIDTH = 3
) (
  input logic clk_in,
  input logic rst_in,
  mem_port_arbiter_if.slave bus
);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic                ld_grant;
  logic                st_grant;
  logic [STARVE_W-1:0] starve_cnt_reg, starve_cnt_next;

  logic                    issue_en_reg, issue_en_next;
  logic                    issue_load_reg, issue_load_next;
  logic [3:0]              issue_we_reg, issue_we_next;
  logic [ADDR_WIDTH-1:0]   issue_addr_reg, issue_addr_next;
  logic [31:0]             issue_wdata_reg, issue_wdata_next;
  logic [ROB_IX_WIDTH-1:0] issue_ix_reg, issue_ix_next;

  logic [MEM_LATENCY-1:0]                   tag_valid_reg, tag_valid_next;
  logic [MEM_LATENCY-1:0][ROB_IX_WIDTH-1:0] tag_ix_reg, tag_ix_next;

  logic                    resp_valid_reg;
  logic [31:0]             resp_data_reg;
  logic [ROB_IX_WIDTH-1:0] resp_ix_reg;

  // Stores drain by default; a load only wins alone or once starved.
  always_comb begin
    ld_grant = !rst_in && bus.ld_valid_in && !bus.flush_in &&
               (!bus.st_valid_in || starve_cnt_reg == STARVE_W'(STARVE_LIMIT));
    st_grant = !rst_in && bus.st_valid_in && !ld_grant;
  end

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (bus.flush_in || !bus.ld_valid_in || ld_grant)
      starve_cnt_next = '0;
    else if (st_grant && starve_cnt_reg != STARVE_W'(STARVE_LIMIT))
      starve_cnt_next = starve_cnt_reg + STARVE_W'(1);
  end

  always_comb begin
    issue_en_next    = ld_grant || st_grant;
    issue_load_next  = ld_grant;
    issue_we_next    = 4'b0000;
    issue_addr_next  = issue_addr_reg;
    issue_wdata_next = 32'h0;
    issue_ix_next    = issue_ix_reg;
    if (st_grant) begin
      issue_we_next    = bus.st_strb_in;
      issue_addr_next  = bus.st_addr_in[ADDR_WIDTH+1:2];
      issue_wdata_next = bus.st_data_in;
    end else if (ld_grant) begin
      issue_addr_next = bus.ld_addr_in[ADDR_WIDTH+1:2];
      issue_ix_next   = bus.ld_rob_ix_in;
    end
  end

  // Stage 0 is loaded during the BRAM enable cycle; flush kills every stage.
  generate
    for (genvar gi = 0; gi < MEM_LATENCY; gi++) begin : g_tag
      if (gi == 0) begin : g_first
        assign tag_valid_next[gi] = issue_en_reg && issue_load_reg && !bus.flush_in;
        assign tag_ix_next[gi]    = issue_ix_reg;
      end else begin : g_rest
        assign tag_valid_next[gi] = tag_valid_reg[gi-1] && !bus.flush_in;
        assign tag_ix_next[gi]    = tag_ix_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      starve_cnt_reg  <= '0;
      issue_en_reg    <= 1'b0;
      issue_load_reg  <= 1'b0;
      issue_we_reg    <= 4'b0000;
      issue_addr_reg  <= '0;
      issue_wdata_reg <= 32'h0;
      issue_ix_reg    <= '0;
      tag_valid_reg   <= '0;
      tag_ix_reg      <= '0;
      resp_valid_reg  <= 1'b0;
      resp_data_reg   <= 32'h0;
      resp_ix_reg     <= '0;
    end else begin
      starve_cnt_reg  <= starve_cnt_next;
      issue_en_reg    <= issue_en_next;
      issue_load_reg  <= issue_load_next;
      issue_we_reg    <= issue_we_next;
      issue_addr_reg  <= issue_addr_next;
      issue_wdata_reg <= issue_wdata_next;
      issue_ix_reg    <= issue_ix_next;
      tag_valid_reg   <= tag_valid_next;
      tag_ix_reg      <= tag_ix_next;
      resp_valid_reg  <= tag_valid_reg[MEM_LATENCY-1] && !bus.flush_in;
      if (tag_valid_reg[MEM_LATENCY-1] && !bus.flush_in) begin
        resp_data_reg <= bus.mem_rdata_in;
        resp_ix_reg   <= tag_ix_reg[MEM_LATENCY-1];
      end
    end
  end

  assign bus.ld_ready_out       = ld_grant;
  assign bus.st_ready_out       = st_grant;
  assign bus.mem_en_out         = issue_en_reg;
  assign bus.mem_we_out         = issue_we_reg;
  assign bus.mem_addr_out       = issue_addr_reg;
  assign bus.mem_wdata_out      = issue_wdata_reg;
  assign bus.ld_resp_valid_out  = resp_valid_reg;
  assign bus.ld_resp_data_out   = resp_data_reg;
  assign bus.ld_resp_rob_ix_out = resp_ix_reg;

  // Byte offset and bits above the BRAM range are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.ld_addr_in[31:ADDR_WIDTH+2], bus.ld_addr_in[1:0],
                              bus.st_addr_in[31:ADDR_WIDTH+2], bus.st_addr_in[1:0]};
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 2-cycle byte-write BRAM model.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(10), .ROB_IX_WIDTH(3)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH(10), .MEM_LATENCY(2), .STARVE_LIMIT(4), .ROB_IX_WIDTH(3)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus)
  );

  // BRAM model: registered address, data valid two cycles later.
  logic [31:0] bram [1024];
  logic [31:0] rd_stage;
  always @(posedge clk) begin
    if (bus.mem_en_out) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we_out[b]) bram[bus.mem_addr_out][8*b +: 8] <= bus.mem_wdata_out[8*b +: 8];
      rd_stage <= bram[bus.mem_addr_out];
    end
    bus.mem_rdata_in <= rd_stage;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bus.st_valid_in = 1'b1;
    bus.st_addr_in  = addr;
    bus.st_data_in  = data;
    bus.st_strb_in  = strb;
    settle();
    check_eq("preload_st_ready", bus.st_ready_out, 1);
    tick();
    bus.st_valid_in = 1'b0;
    $display("store addr=0x%08h data=0x%08h strb=%b", addr, data, strb);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp_b2b [4];

  initial begin
    rst = 1'b1;
    bus.flush_in = 0; bus.ld_valid_in = 0; bus.ld_addr_in = 0; bus.ld_rob_ix_in = 0;
    bus.st_valid_in = 0; bus.st_addr_in = 0; bus.st_data_in = 0; bus.st_strb_in = 0;
    tick();
    bus.st_valid_in = 1'b1;
    bus.ld_valid_in = 1'b1;
    settle();
    check_eq("rst_st_ready", bus.st_ready_out, 0);
    check_eq("rst_ld_ready", bus.ld_ready_out, 0);
    tick();
    check_eq("rst_mem_en", bus.mem_en_out, 0);
    check_eq("rst_mem_we", bus.mem_we_out, 0);
    check_eq("rst_resp_valid", bus.ld_resp_valid_out, 0);
    check_eq("rst_resp_data", bus.ld_resp_data_out, 0);
    bus.st_valid_in = 1'b0;
    bus.ld_valid_in = 1'b0;
    rst = 1'b0;
    tick();

    do_store(32'h0000_0000, 32'hC0DE_0000, 4'b1111);
    do_store(32'h0000_0004, 32'hC0DE_0001, 4'b1111);
    do_store(32'h0000_0008, 32'hAAAA_BBBB, 4'b1111);
    do_store(32'h0000_000C, 32'hC0DE_0003, 4'b1111);
    do_store(32'h0000_0010, 32'hDEAD_BEEF, 4'b1111);
    do_store(32'h0000_0020, 32'h0BAD_F00D, 4'b1111);

    // Single load
    bus.ld_valid_in = 1'b1; bus.ld_addr_in = 32'h10; bus.ld_rob_ix_in = 3'd5;
    settle();
    check_eq("t1_ld_ready", bus.ld_ready_out, 1);
    check_eq("t1_st_ready", bus.st_ready_out, 0);
    tick();
    bus.ld_valid_in = 1'b0;
    check_eq("t1_mem_en", bus.mem_en_out, 1);
    check_eq("t1_mem_addr", bus.mem_addr_out, 4);
    check_eq("t1_mem_we", bus.mem_we_out, 0);
    check_eq("t1_mem_wdata", bus.mem_wdata_out, 0);
    tick();
    check_eq("t1_resp_c2", bus.ld_resp_valid_out, 0);
    tick();
    check_eq("t1_resp_c3", bus.ld_resp_valid_out, 0);
    tick();
    check_eq("t1_resp_c4", bus.ld_resp_valid_out, 1);
    check_eq("t1_resp_data", bus.ld_resp_data_out, 32'hDEAD_BEEF);
    check_eq("t1_resp_ix", bus.ld_resp_rob_ix_out, 5);
    $display("load ix=%0d data=0x%08h", bus.ld_resp_rob_ix_out, bus.ld_resp_data_out);
    tick();
    check_eq("t1_resp_c5", bus.ld_resp_valid_out, 0);

    // Store then load to the same word
    bus.st_valid_in = 1'b1; bus.st_addr_in = 32'h8; bus.st_data_in = 32'h1234_5678; bus.st_strb_in = 4'b0011;
    settle();
    check_eq("t2_st_ready", bus.st_ready_out, 1);
    tick();
    bus.st_valid_in = 1'b0;
    bus.ld_valid_in = 1'b1; bus.ld_addr_in = 32'h8; bus.ld_rob_ix_in = 3'd2;
    settle();
    check_eq("t2_ld_ready", bus.ld_ready_out, 1);
    check_eq("t2_mem_we", bus.mem_we_out, 4'b0011);
    check_eq("t2_mem_wdata", bus.mem_wdata_out, 32'h1234_5678);
    check_eq("t2_mem_addr", bus.mem_addr_out, 2);
    tick();
    bus.ld_valid_in = 1'b0;
    repeat (3) tick();
    check_eq("t2_resp_valid", bus.ld_resp_valid_out, 1);
    check_eq("t2_resp_data", bus.ld_resp_data_out, 32'hAAAA_5678);
    check_eq("t2_resp_ix", bus.ld_resp_rob_ix_out, 2);
    $display("load ix=%0d data=0x%08h", bus.ld_resp_rob_ix_out, bus.ld_resp_data_out);
    repeat (2) tick();

    // Starvation: both requesters held high
    bus.st_valid_in = 1'b1; bus.st_addr_in = 32'h100; bus.st_data_in = 32'h0; bus.st_strb_in = 4'b1111;
    bus.ld_valid_in = 1'b1; bus.ld_addr_in = 32'h20; bus.ld_rob_ix_in = 3'd1;
    for (int i = 0; i < 5; i++) begin
      bus.st_data_in = 32'h100 + i;
      settle();
      check_eq($sformatf("t3_st_ready_c%0d", i), bus.st_ready_out, (i < 4) ? 1 : 0);
      check_eq($sformatf("t3_ld_ready_c%0d", i), bus.ld_ready_out, (i < 4) ? 0 : 1);
      tick();
    end
    bus.ld_rob_ix_in = 3'd2; bus.ld_addr_in = 32'h24;
    settle();
    check_eq("t3_resume_st", bus.st_ready_out, 1);
    check_eq("t3_resume_ld", bus.ld_ready_out, 0);
    tick();
    bus.st_valid_in = 1'b0; bus.ld_valid_in = 1'b0;
    repeat (2) tick();
    check_eq("t3_resp_valid", bus.ld_resp_valid_out, 1);
    check_eq("t3_resp_data", bus.ld_resp_data_out, 32'h0BAD_F00D);
    check_eq("t3_resp_ix", bus.ld_resp_rob_ix_out, 1);
    $display("load ix=%0d data=0x%08h", bus.ld_resp_rob_ix_out, bus.ld_resp_data_out);
    repeat (2) tick();

    // Flush cancels in-flight loads
    for (int i = 0; i < 3; i++) begin
      bus.ld_valid_in = 1'b1; bus.ld_addr_in = 32'(4 * i); bus.ld_rob_ix_in = 3'(i + 1);
      settle();
      check_eq($sformatf("t4_ld_ready_%0d", i), bus.ld_ready_out, 1);
      tick();
    end
    bus.ld_addr_in = 32'hC; bus.ld_rob_ix_in = 3'd4;
    bus.flush_in = 1'b1;
    bus.st_valid_in = 1'b1; bus.st_addr_in = 32'h104; bus.st_data_in = 32'h55; bus.st_strb_in = 4'b0001;
    settle();
    check_eq("t4_flush_ld_ready", bus.ld_ready_out, 0);
    check_eq("t4_flush_st_ready", bus.st_ready_out, 1);
    tick();
    bus.st_valid_in = 1'b0;
    settle();
    check_eq("t4_flush_ld_only", bus.ld_ready_out, 0);
    check_eq("t4_store_we", bus.mem_we_out, 4'b0001);
    check_eq("t4_resp_c4", bus.ld_resp_valid_out, 0);
    tick();
    bus.flush_in = 1'b0; bus.ld_valid_in = 1'b0;
    check_eq("t4_resp_c5", bus.ld_resp_valid_out, 0);
    tick();
    check_eq("t4_resp_c6", bus.ld_resp_valid_out, 0);
    tick();
    check_eq("t4_resp_c7", bus.ld_resp_valid_out, 0);
    tick();

    // Back-to-back loads
    exp_b2b[0] = 32'hC0DE_0000; exp_b2b[1] = 32'hC0DE_0001;
    exp_b2b[2] = 32'hAAAA_5678; exp_b2b[3] = 32'hC0DE_0003;
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid_in = 1'b1; bus.ld_addr_in = 32'(4 * i); bus.ld_rob_ix_in = 3'(i);
      settle();
      check_eq($sformatf("t5_ld_ready_%0d", i), bus.ld_ready_out, 1);
      tick();
    end
    bus.ld_valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t5_resp_valid_%0d", i), bus.ld_resp_valid_out, 1);
      check_eq($sformatf("t5_resp_ix_%0d", i), bus.ld_resp_rob_ix_out, 32'(i));
      check_eq($sformatf("t5_resp_data_%0d", i), bus.ld_resp_data_out, exp_b2b[i]);
      $display("load ix=%0d data=0x%08h", bus.ld_resp_rob_ix_out, bus.ld_resp_data_out);
      tick();
    end
    check_eq("t5_resp_after", bus.ld_resp_valid_out, 0);
    tick();

    // Reset mid-flight
    bus.ld_valid_in = 1'b1; bus.ld_addr_in = 32'h10; bus.ld_rob_ix_in = 3'd6;
    settle();
    check_eq("t6_ld_ready", bus.ld_ready_out, 1);
    tick();
    bus.ld_valid_in = 1'b0;
    tick();
    rst = 1'b1;
    bus.st_valid_in = 1'b1; bus.st_addr_in = 32'h108; bus.st_data_in = 32'h77; bus.st_strb_in = 4'b1111;
    settle();
    check_eq("t6_rst_st_ready", bus.st_ready_out, 0);
    tick();
    rst = 1'b0;
    bus.st_valid_in = 1'b0;
    check_eq("t6_resp_data_cleared", bus.ld_resp_data_out, 0);
    check_eq("t6_resp_ix_cleared", bus.ld_resp_rob_ix_out, 0);
    for (int c = 3; c <= 8; c++) begin
      check_eq($sformatf("t6_resp_valid_c%0d", c), bus.ld_resp_valid_out, 0);
      check_eq($sformatf("t6_mem_en_c%0d", c), bus.mem_en_out, 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory BRAM port between two requesters: load issue from the load buffer, and committed stores from the ROB head.
- Registers the granted access onto the BRAM.
- Tracks in-flight reads with a tag pipeline and returns load data tagged with its ROB index.
- Sits between load_buffer/ROB and the data BRAM.

Parameters:
- ADDR_WIDTH, 10, BRAM word-address width (port byte addresses are 32 bits).
- MEM_LATENCY, 2, BRAM read latency in cycles from registered address to valid mem_rdata_in.
- STARVE_LIMIT, 4, consecutive cycles a pending load may lose to stores before it is force-granted.
- ROB_IX_WIDTH, 3, width of the ROB index tag.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset.
- flush_in  input  1  mispredict flush; cancels speculative loads.
- ld_valid_in  input  1  load request valid.
- ld_addr_in  input  32  load byte address.
- ld_rob_ix_in  input  ROB_IX_WIDTH  ROB index of the load.
- ld_ready_out  output  1  load accepted this cycle.
- st_valid_in  input  1  committed store valid.
- st_addr_in  input  32  store byte address.
- st_data_in  input  32  store data, lane-aligned.
- st_strb_in  input  4  byte-write strobes.
- st_ready_out  output  1  store accepted this cycle.
- mem_en_out  output  1  BRAM enable.
- mem_we_out  output  4  BRAM byte write enables.
- mem_addr_out  output  ADDR_WIDTH  BRAM word address.
- mem_wdata_out  output  32  BRAM write data.
- mem_rdata_in  input  32  BRAM read data.
- ld_resp_valid_out  output  1  load data valid.
- ld_resp_data_out  output  32  full loaded word.
- ld_resp_rob_ix_out  output  ROB_IX_WIDTH  tag of returned load.

Interface decision: one clock, clk_in; rst_in is synchronous, active-high.

Behaviour:
- Handshake:
  - Transfer occurs on valid & ready.
  - ld_ready_out and st_ready_out are combinational grant signals; at most one is high per cycle.
  - Requesters hold valid and payload stable until accepted.
- Grant rule:
  - Stores win by default, because commit must drain.
  - Exception: a load wins when starve_cnt == STARVE_LIMIT.
  - When only one requester is valid, it wins.
- flush_in:
  - While flush_in is high, ld_ready_out = 0.
  - Stores are still granted; stores are non-speculative and never cancelled.
- starve_cnt (0..STARVE_LIMIT):
  - Increments each cycle a store is granted while ld_valid_in is high and flush_in is low.
  - Clears when a load is granted, when ld_valid_in is low, or on flush.
- Issue register:
  - Cycle after acceptance: mem_en_out = 1; mem_addr_out = addr[ADDR_WIDTH+1:2].
  - Store: mem_we_out = st_strb_in, mem_wdata_out = st_data_in.
  - Load: mem_we_out = 0, mem_wdata_out = 0.
  - Idle cycle: mem_en_out = 0, mem_we_out = 0.
  - Address bits [1:0] are ignored; byte/half extraction and sign-extension are downstream.
- Tag pipeline:
  - Shift register of MEM_LATENCY stages, each {valid, rob_ix}.
  - Entered on the mem_en_out cycle of a load read.
  - Stage MEM_LATENCY-1 valid means mem_rdata_in is valid that cycle.
  - Response outputs are registered from that stage.
- Latency:
  - Load accepted in cycle N gives ld_resp_valid_out high in cycle N+2+MEM_LATENCY (N+4 at default), for exactly one cycle.
  - Throughput is one access per cycle; back-to-back loads return back-to-back in issue order.
- Flush effect:
  - All tag-pipeline valid bits clear on the flush edge.
  - ld_resp_valid_out is 0 in the cycle following a flush.
  - The BRAM read still completes; its data is discarded.
- Ordering:
  - Memory order equals grant order.
  - A store granted in cycle N followed by a load to the same word granted in cycle N+1 or later returns the new data.
  - RAW across a store still queued in the ROB is not this block's concern.
- Reset values:
  - All outputs 0, except ld_ready_out/st_ready_out, which follow the grant logic combinationally and are 0 while rst_in is high.
  - Tag pipeline valid bits, issue register and starve_cnt are all 0.
  - Reset mid-flight drops every outstanding response; no response is emitted after reset deasserts.

Test Plan:
- Single load, ld_addr_in=0x0000_0010, ld_rob_ix_in=5, BRAM word 4 = 0xDEADBEEF, accepted cycle 0 -> mem_en_out=1 and mem_addr_out=4 in cycle 1; ld_resp_valid_out=1, ld_resp_data_out=0xDEADBEEF, ld_resp_rob_ix_out=5 in cycle 4 only.
- Store then load: store addr 0x8, data 0x12345678, strb 4'b0011, accepted cycle 0; load addr 0x8 accepted cycle 1 -> mem_we_out=4'b0011 in cycle 1; load returns 0xXXXX5678 (prior upper half preserved) in cycle 5.
- Starvation: st_valid_in and ld_valid_in held high continuously, STARVE_LIMIT=4 -> stores granted cycles 0-3, load granted cycle 4, stores resume cycle 5; starve_cnt is 0 after cycle 4.
- Flush: loads with rob_ix 1, 2, 3 accepted cycles 0-2, flush_in pulsed in cycle 3 with a store valid -> no ld_resp_valid_out in cycles 4-6; store granted in cycle 3; ld_ready_out=0 in cycle 3.
- Back-to-back loads: rob_ix 0..3 at addresses 0x0, 0x4, 0x8, 0xC in cycles 0-3 -> responses in cycles 4-7 in the same order with the correct data.
- Reset mid-flight: load accepted cycle 0, rst_in high in cycle 2 -> all outputs 0 and no ld_resp_valid_out in cycles 3-8.
